// File: rtl/mem_array_nand.sv
// Word-level storage array: DEPTH x DATA_WIDTH, registered read with valid flag,
// per-bit write masking and a sequenced bulk-clear sweep.
module mem_array_nand #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  r_w,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic                  clr,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0]   mem_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      state_q    <= StIdle;
      cnt_q      <= '0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Result flags are single-cycle pulses; dout is zero unless qualified.
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clr) begin
            state_q <= StClear;
            busy    <= 1'b1;
            cnt_q   <= '0;
            err     <= sel;
          end else if (sel) begin
            if (r_w) begin
              mem_q[addr] <= (mem_q[addr] & ~wmask) | (din & wmask);
            end else begin
              dout       <= mem_q[addr];
              dout_valid <= 1'b1;
            end
          end
        end
        StClear: begin
          mem_q[cnt_q] <= '0;
          cnt_q        <= cnt_q + ADDR_WIDTH'(1);
          err          <= sel;
          // Counter wrap from the last word ends the sweep; clr is ignored here.
          if (cnt_q == ADDR_WIDTH'(Depth - 1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_array_nand.sv
// Directed self-checking bench for mem_array_nand (DATA_WIDTH = 8, ADDR_WIDTH = 4).
module tb_mem_array_nand;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       r_w;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] wmask;
  logic       clr;
  logic       busy;
  logic [7:0] dout;
  logic       dout_valid;
  logic       err;

  int total = 0;
  int bad = 0;

  mem_array_nand #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .r_w       (r_w),
    .addr      (addr),
    .din       (din),
    .wmask     (wmask),
    .clr       (clr),
    .busy      (busy),
    .dout      (dout),
    .dout_valid(dout_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sel = 1'b0; r_w = 1'b0; clr = 1'b0; wmask = 8'h00; din = 8'h00;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    sel = 1'b1; r_w = 1'b1; clr = 1'b0; addr = a; din = d; wmask = m;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    addr = 4'd0;
    #12;
    total++;
    if ({busy, err, dout_valid, dout} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b err=%b vld=%b dout=%h, want all 0",
               busy, err, dout_valid, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read_zero();
    for (int a = 0; a < 16; a++) begin
      sel = 1'b1; r_w = 1'b0; addr = 4'(a);
      step();
      total++;
      if (dout_valid !== 1'b1 || dout !== 8'h00) begin
        bad++;
        $display("FAIL read_zero[%0d]: got vld=%b dout=%h, want vld=1 dout=00", a, dout_valid, dout);
      end
    end
    idle();
    step();
    total++;
    if (dout_valid !== 1'b0 || dout !== 8'h00) begin
      bad++;
      $display("FAIL idle_after_read: got vld=%b dout=%h, want vld=0 dout=00", dout_valid, dout);
    end
  endtask

  task automatic test_write_read();
    sel = 1'b1; r_w = 1'b1; addr = 4'd3; din = 8'hA5; wmask = 8'hFF;
    step();
    total++;
    if (dout_valid !== 1'b0 || dout !== 8'h00) begin
      bad++;
      $display("FAIL write_no_valid: got vld=%b dout=%h, want vld=0 dout=00", dout_valid, dout);
    end
    r_w = 1'b0; din = 8'h00; wmask = 8'h00;
    step();
    total++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
      bad++;
      $display("FAIL read_after_write: got vld=%b dout=%h, want vld=1 dout=a5", dout_valid, dout);
    end
    idle();
    step();
    total++;
    if (dout_valid !== 1'b0 || dout !== 8'h00) begin
      bad++;
      $display("FAIL valid_pulse: got vld=%b dout=%h, want vld=0 dout=00", dout_valid, dout);
    end
  endtask

  task automatic test_mask();
    do_write(4'd3, 8'h0F, 8'h3C);
    do_write(4'd3, 8'hFF, 8'h00);
    sel = 1'b1; r_w = 1'b0; addr = 4'd3;
    step();
    idle();
    total++;
    if (dout_valid !== 1'b1 || dout !== 8'h8D) begin
      bad++;
      $display("FAIL masked_merge: got vld=%b dout=%h, want vld=1 dout=8d", dout_valid, dout);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL zero_mask_err: got err=%b, want 0", err);
    end
  endtask

  task automatic test_clear_sweep();
    int busy_cycles = 0;
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'h10 + 8'(a), 8'hFF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (busy === 1'b1) busy_cycles++;
      sel = (i == 5); r_w = 1'b0; addr = 4'd15;
      step();
      total++;
      if (err !== (i == 5) || dout_valid !== 1'b0) begin
        bad++;
        $display("FAIL sweep_cycle[%0d]: got err=%b vld=%b, want err=%b vld=0",
                 i, err, dout_valid, (i == 5));
      end
    end
    idle();
    total++;
    if (busy_cycles != 16 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_length: got %0d cycles, busy now=%b, want 16 and 0", busy_cycles, busy);
    end
    sel = 1'b1; r_w = 1'b0; addr = 4'd15;
    step();
    addr = 4'd0;
    total++;
    if (dout_valid !== 1'b1 || dout !== 8'h00) begin
      bad++;
      $display("FAIL after_clear_15: got vld=%b dout=%h, want vld=1 dout=00", dout_valid, dout);
    end
    step();
    idle();
    total++;
    if (dout_valid !== 1'b1 || dout !== 8'h00) begin
      bad++;
      $display("FAIL after_clear_0: got vld=%b dout=%h, want vld=1 dout=00", dout_valid, dout);
    end
  endtask

  task automatic test_clr_with_write();
    int n = 1;
    do_write(4'd7, 8'h77, 8'hFF);
    clr = 1'b1; sel = 1'b1; r_w = 1'b1; addr = 4'd7; din = 8'hFF; wmask = 8'hFF;
    step();
    idle();
    total++;
    if (err !== 1'b1 || busy !== 1'b1 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL clr_wins: got err=%b busy=%b vld=%b, want 1 1 0", err, busy, dout_valid);
    end
    // Drive clr again mid-sweep; it must not extend the sweep.
    clr = 1'b1;
    while (busy === 1'b1 && n < 40) begin
      step();
      clr = 1'b0;
      if (busy === 1'b1) n++;
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL clr_sweep_len: got %0d busy cycles, want 16", n);
    end
    sel = 1'b1; r_w = 1'b0; addr = 4'd7;
    step();
    idle();
    total++;
    if (dout_valid !== 1'b1 || dout !== 8'h00) begin
      bad++;
      $display("FAIL addr7_cleared: got vld=%b dout=%h, want vld=1 dout=00", dout_valid, dout);
    end
  endtask

  task automatic test_async_reset();
    do_write(4'd2, 8'h5A, 8'hFF);
    sel = 1'b1; r_w = 1'b0; addr = 4'd2;
    step();
    idle();
    total++;
    if (dout_valid !== 1'b1 || dout !== 8'h5A) begin
      bad++;
      $display("FAIL pre_reset_read: got vld=%b dout=%h, want vld=1 dout=5a", dout_valid, dout);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dout_valid !== 1'b0 || dout !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_read: got vld=%b dout=%h, want vld=0 dout=00", dout_valid, dout);
    end
    rst_n = 1'b1;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    sel = 1'b1; r_w = 1'b0; addr = 4'd9;
    step();
    idle();
    total++;
    if (busy !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_sweep: got busy=%b err=%b, want 1 1", busy, err);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, err, dout_valid, dout} !== 11'd0) begin
      bad++;
      $display("FAIL reset_mid_sweep: got busy=%b err=%b vld=%b dout=%h, want all 0",
               busy, err, dout_valid, dout);
    end
    rst_n = 1'b1;
    sel = 1'b1; r_w = 1'b0; addr = 4'd2;
    step();
    idle();
    total++;
    if (dout_valid !== 1'b1 || dout !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL read_after_reset: got vld=%b dout=%h busy=%b, want 1 00 0",
               dout_valid, dout, busy);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_write_read();
    test_mask();
    test_clear_sweep();
    test_clr_with_write();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_array_nand.md
Name: mem_array_nand

Overview:
- Parametrised successor to the single NAND-latch bitcell: a DEPTH x DATA_WIDTH storage array with the same sel / r_w access protocol.
- Adds four things the bitcell lacks: a clock, a registered read with a valid flag, per-bit write masking, and a sequenced bulk-clear state machine.
- Serves as the word-level memory macro above the bitcell layer for small register-file and scratchpad uses.

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words, so every address is valid.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sel  input  1  access select; no access occurs when low.
- r_w  input  1  1 = write, 0 = read; qualified by sel.
- addr  input  ADDR_WIDTH  word address.
- din  input  DATA_WIDTH  write data.
- wmask  input  DATA_WIDTH  per-bit write enable; 1 = update that bit.
- clr  input  1  bulk-clear request, sampled one cycle at a time.
- busy  output  1  high while a clear sweep is in progress.
- dout  output  DATA_WIDTH  read data; all zeros whenever dout_valid = 0.
- dout_valid  output  1  one-cycle pulse qualifying dout.
- err  output  1  one-cycle pulse marking a rejected access.

Behaviour:
- Reset: rst_n low clears every array word, dout, dout_valid, busy, err and the clear counter to 0, and puts the FSM in IDLE, without waiting for clk.
- FSM states are IDLE and CLEAR.
- Write (IDLE, sel = 1, r_w = 1):
  - At the edge, mem[addr] <= (mem[addr] & ~wmask) | (din & wmask).
  - wmask = 0 leaves the word unchanged; this is legal and sets no error.
  - dout_valid = 0 in the following cycle.
- Read (IDLE, sel = 1, r_w = 0):
  - Latency is 1 cycle: the cycle after the request, dout = mem[addr] and dout_valid = 1.
  - Back-to-back reads give one result per cycle.
- Read after write: a read issued the cycle after a write to the same address returns the new data. There is no same-cycle conflict because the array is single-ported.
- Idle cycle (sel = 0): no array change; dout = 0 and dout_valid = 0 next cycle.
- Clear request (IDLE, clr = 1):
  - The FSM moves to CLEAR and busy = 1 from the next cycle.
  - The counter starts at 0 and zeroes word[counter] on each CLEAR cycle.
  - After word DEPTH-1 is cleared (DEPTH cycles in CLEAR) the FSM returns to IDLE and busy drops.
  - The first access accepted after busy falls sees zeros.
- Simultaneous clr and sel in IDLE: clr wins. The access is dropped, err = 1 next cycle, and no array write or read result occurs.
- Any sel = 1 during CLEAR: the access is dropped, err = 1 next cycle, dout_valid = 0.
- clr during CLEAR: ignored; the sweep does not restart or extend.
- err is a single-cycle pulse per rejected request; consecutive rejected cycles give err high on each following cycle.
- Reset asserted mid-CLEAR or mid-read: the operation aborts immediately and all outputs and the array return to reset values.
- Width rules: masks apply bitwise; no arithmetic on data; the counter is ADDR_WIDTH bits and its wrap from DEPTH-1 to 0 ends the sweep.

Test Plan (DATA_WIDTH = 8, ADDR_WIDTH = 4):
- Release rst_n, then read addr 0..15 back-to-back -> dout_valid = 1 on each following cycle, with dout = 0x00 every time.
- Write addr 3, din = 0xA5, wmask = 0xFF; next cycle read addr 3 -> one cycle later dout = 0xA5, dout_valid = 1; the cycle after that, dout_valid = 0 and dout = 0x00.
- With addr 3 = 0xA5, write din = 0x0F, wmask = 0x3C; read addr 3 -> dout = 0x8D (masked merge).
- Fill addr 0..15 with 0x10+addr; pulse clr; hold sel = 1 read on cycle 5 of the sweep -> busy = 1 for exactly 16 cycles, err = 1 for that one cycle, dout_valid stays 0; afterwards, reading addr 15 -> 0x00.
- Same cycle clr = 1 with a write of 0xFF to addr 7 -> err = 1 next cycle, the sweep runs, and addr 7 reads 0x00 afterwards.
- Assert rst_n low mid-sweep and during a pending read, asynchronously between edges -> busy, err, dout_valid and dout go to 0 immediately; a read after release returns 0x00.
